// File: rtl/mdu_pkg.sv
// Shared encodings and sizing constants for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation codes presented on the op port together with start.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states: IDLE -> RUN (WIDTH iterations) -> FIX (sign fixup) -> DONE (write strobe).
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit feeding the hilo register.
// Signed operands are reduced to magnitudes at capture, a fixed WIDTH-cycle
// shift-add or restoring-divide loop runs on the magnitudes, and the signs are
// restored in FIX. The {HI,LO} result is strobed out for one cycle in DONE.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic [2*WIDTH-1:0] hilo_d,
  output logic               hilo_write
);

  localparam int                CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ZERO = '0;
  localparam logic [WIDTH-1:0]  ONES = '1;

  // Conditional two's-complement negate, used both to take magnitudes at
  // capture and to restore signs in FIX.
  function automatic logic [2*WIDTH-1:0] neg_if(input logic [2*WIDTH-1:0] v,
                                                input logic               neg);
    return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e             state_q,   state_d;
  logic [CW-1:0]      count_q,   count_d;
  op_e                op_q,      op_d;
  logic [WIDTH-1:0]   a_raw_q,   a_raw_d;   // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   mag_a_q,   mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,   mag_b_d;
  logic               neg_res_q, neg_res_d; // operand signs differ
  logic               neg_rem_q, neg_rem_d; // dividend was negative
  logic [2*WIDTH-1:0] acc_q,     acc_d;     // {HI,LO} working accumulator
  logic [2*WIDTH-1:0] res_q,     res_d;     // registered result presented on hilo_d

  op_e                op_in;
  logic               is_signed, is_div_in, is_div_q;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH-1:0]   unused_a, unused_b, unused_q, unused_r;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;

  // Next-state, datapath iteration and result fixup.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    a_raw_d   = a_raw_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    res_d     = res_q;

    // Capture-side magnitudes; only the low half of each negate is meaningful.
    op_in     = op_e'(op);
    is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    is_div_in = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    sign_a    = is_signed & a[WIDTH-1];
    sign_b    = is_signed & b[WIDTH-1];
    {unused_a, abs_a} = neg_if({ZERO, a}, sign_a);
    {unused_b, abs_b} = neg_if({ZERO, b}, sign_b);

    // One iteration step for each algorithm.
    is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : {1'b0, ZERO});
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};

    // Sign restoration applied in FIX.
    {unused_q, quo_fix} = neg_if({ZERO, acc_q[WIDTH-1:0]}, neg_res_q);
    {unused_r, rem_fix} = neg_if({ZERO, acc_q[2*WIDTH-1:WIDTH]}, neg_rem_q);
    prod_fix            = neg_if(acc_q, neg_res_q);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          state_d   = RUN;
          count_d   = '0;
          op_d      = op_in;
          a_raw_d   = a;
          mag_a_d   = abs_a;
          mag_b_d   = abs_b;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          // Multiply shifts the multiplier out of LO; divide shifts the dividend out of LO.
          acc_d     = is_div_in ? {ZERO, abs_a} : {ZERO, abs_b};
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the shifted remainder when the trial subtract borrows.
            if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (count_q == LAST) state_d = FIX;
          else                 count_d = count_q + CW'(1);
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (!is_div_q)             res_d = prod_fix;
          else if (mag_b_q == ZERO)  res_d = {a_raw_q, ONES};
          else                       res_d = {rem_fix, quo_fix};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= OP_MULT;
      a_raw_q   <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      a_raw_q   <= a_raw_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == FIX);
  assign hilo_write = (state_q == DONE);
  assign hilo_d     = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected {HI,LO} values,
// a monitor pops and compares on every hilo_write strobe.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           hilo_write;
  logic [2*W-1:0] hilo_d;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .hilo_d     (hilo_d),
    .hilo_write (hilo_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && hilo_write) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", 64'(hilo_write), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check(e.name, hilo_d, e.exp);
        end
      end
    end
  end

  // Issue one operation; start is sampled on the rising edge after this negedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input bit expect_it, input string name, input logic [63:0] exp);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    if (expect_it) begin
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t        vecs[8];
  logic [63:0] last_exp;
  int          c;

  initial begin : stim
    vecs[0] = '{"multu_max",   2'(OP_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{"mult_minmin", 2'(OP_MULT),  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{"div_neg7_2",  2'(OP_DIV),   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{"div_7_neg2",  2'(OP_DIV),   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    vecs[4] = '{"divu_100_7",  2'(OP_DIVU),  32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[5] = '{"divu_by0",    2'(OP_DIVU),  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF};
    vecs[6] = '{"div_by0_neg", 2'(OP_DIV),   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
    vecs[7] = '{"div_ovf",     2'(OP_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_hilo_write", 64'(hilo_write), 64'd0);
    check("rst_hilo_d",     hilo_d,          64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -3 * 7 with cycle-exact busy/write timing (j-th negedge after the start edge).
    issue(2'(OP_MULT), 32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg3_7", 64'hFFFF_FFFF_FFFF_FFEB);
    for (int j = 1; j <= 35; j++) begin
      if (j == 1 || j == 33 || j == 34)
        check($sformatf("busy_j%0d", j), 64'(busy), 64'(j <= 33));
      if (j >= 33)
        check($sformatf("write_j%0d", j), 64'(hilo_write), 64'(j == 34));
      if (j < 35) @(negedge clk);
    end
    drain(10);

    // Directed arithmetic vectors.
    last_exp = 64'hFFFF_FFFF_FFFF_FFEB;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].name, vecs[i].exp);
      drain(60);
      last_exp = vecs[i].exp;
    end

    // flush together with start in IDLE: nothing is accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'(OP_MULTU); a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // flush in RUN at count=10: back to IDLE, hilo_d held, no write.
    issue(2'(OP_DIVU), 32'd1000, 32'd3, 1'b0, "", 64'd0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",   64'(busy), 64'd0);
    check("flush_hold_d", hilo_d,    last_exp);
    repeat (40) @(negedge clk);

    // start while busy is ignored: only the first result appears.
    issue(2'(OP_MULTU), 32'd3, 32'd5, 1'b1, "multu_3_5", 64'd15);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'(OP_MULTU); a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (10) @(negedge clk);
    check("busy_start_ignored", 64'(busy), 64'd0);

    // Back-to-back: new MULT issued in the DONE cycle of the previous one.
    issue(2'(OP_MULT), 32'd6, 32'hFFFF_FFF9, 1'b1, "b2b_first", 64'hFFFF_FFFF_FFFF_FFD6);
    c = 0;
    while (!hilo_write && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("b2b_first_seen", 64'(hilo_write), 64'd1);
    start = 1'b1; op = 2'(OP_MULT); a = 32'd1000; b = 32'd1000;
    begin
      exp_t e;
      e.name = "b2b_second";
      e.exp  = 64'h0000_0000_000F_4240;
      sb_q.push_back(e);
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
    end while (!hilo_write && c < 60);
    check("b2b_spacing", 64'(c), 64'd34);
    drain(10);

    // Asynchronous reset mid-RUN: outputs clear at once, no write afterwards.
    issue(2'(OP_MULTU), 32'd11, 32'd13, 1'b0, "", 64'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_write", 64'(hilo_write), 64'd0);
    check("mid_rst_d",     hilo_d,          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);

    // Unit still operates normally after the abort.
    issue(2'(OP_DIVU), 32'd100, 32'd7, 1'b1, "post_rst_divu", 64'h0000_0002_0000_000E);
    drain(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that executes MULT, MULTU, DIV and DIVU operations.
- Sits directly upstream of the hilo register and drives its d and write inputs.
- Operands come from register-file reads rs/rt. While busy is high the CPU must not issue a dependent HI/LO access.
- Radix-2 shift-add / restoring-divide datapath; fixed latency regardless of operand values.

Parameters:
- WIDTH, 32: operand width. HI/LO result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an operation; sampled on the rising edge
- op  input  2  operation code, captured with start (encodings in mdu_pkg)
- a  input  WIDTH  rs operand (multiplicand / dividend), captured with start
- b  input  WIDTH  rt operand (multiplier / divisor), captured with start
- flush  input  1  synchronous cancel of the in-flight operation
- busy  output  1  operation in progress (state RUN or FIX)
- hilo_d  output  2*WIDTH  result {HI,LO} to the hilo register
- hilo_write  output  1  one-cycle write strobe to the hilo register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, hilo_d=0, hilo_write=0, busy=0. All operand and accumulator registers are cleared.
- Reset mid-operation aborts the operation; no hilo_write is ever produced for it.
- States and transitions:
  - IDLE: when start=1, capture op/a/b, go to RUN, count=0.
  - RUN: one iteration per cycle. Go to FIX when count==WIDTH-1; otherwise count+1.
  - FIX: apply sign correction and register hilo_d; go to DONE.
  - DONE: hilo_write=1 for exactly this cycle. Go to IDLE, or to RUN if start=1 (back-to-back issue permitted).
- Latency: with start sampled at edge t0, hilo_write is high between edges t(WIDTH+1) and t(WIDTH+2). For WIDTH=32 that is edges t33 and t34.
- busy=1 in RUN and FIX only. start is ignored while busy=1.
- flush=1 in RUN or FIX: go to IDLE at the next edge; hilo_d is unchanged and hilo_write is not produced.
- flush and start together in IDLE or DONE: flush wins and no operation is accepted. In DONE the pending write still completes that cycle.
- Signed operations (MULT, DIV): operands are converted to magnitudes at capture. -2^(WIDTH-1) has magnitude 2^(WIDTH-1) as unsigned.
- Product is negated in FIX if the operand signs differ.
- Division results:
  - Quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Quotient goes to LO, remainder to HI.
  - Multiplication: full 2*WIDTH product, upper half to HI, lower half to LO.
- Divide by zero (b==0, any division op): LO = all ones, HI = a (raw captured dividend). No exception.
- DIV -2^(WIDTH-1) / -1: LO = 0x80000000 (natural wrap), HI = 0. No exception.
- hilo_d holds its last value outside DONE. The hilo register only loads on hilo_write.
- No output depends combinationally on inputs. All outputs are registered or decoded from state.

Decomposition:
- mdu_pkg holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state encodings: IDLE, RUN, FIX, DONE
  - count width constant: clog2(WIDTH)
- Single module; no sub-module required. The negate/abs logic is a local function shared by the capture and FIX stages.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> hilo_d=0xFFFFFFFF_FFFFFFEB, hilo_write exactly one cycle at t33-t34, busy high t0..t33.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hilo_d=0xFFFFFFFE_00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3). DIVU a=100, b=7 -> HI=2, LO=14.
- DIVU a=100, b=0 -> HI=0x00000064, LO=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> HI=0, LO=0x80000000.
- Cancellation:
  - flush at RUN count=10 -> IDLE next edge, no hilo_write, hilo_d unchanged.
  - rst_n low mid-RUN -> all outputs 0 immediately.
  - start during busy -> ignored.
- Back-to-back: new MULT with start=1 in the DONE cycle -> first result written, second hilo_write exactly 34 cycles later with the correct product.
